// File: rtl/fifo_ram_pkg.sv
// Shared sizing helpers for frontend FIFO buffers: clog2 plus derived pointer/count widths.
package fifo_ram_pkg;

   localparam int unsigned DefaultWidth     = 32;
   localparam int unsigned DefaultBuffering = 2;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      longint unsigned v;
      r = 0;
      v = 1;
      while (v < longint'(n)) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Pointer width never drops below one bit, even for a single-entry buffer.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (clog2(depth) == 0) ? 1 : clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ram_mem.sv
// Storage array: synchronous write, asynchronous read, suited to distributed RAM.
module fifo_ram_mem
   import fifo_ram_pkg::*;
#(
   parameter int unsigned Width = DefaultWidth,
   parameter int unsigned Depth = DefaultBuffering,
   parameter int unsigned AddrW = ptr_width(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   // Contents are deliberately not reset; validity is tracked by the occupancy count.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_ram.sv
// First-word-fall-through FIFO: pointers, occupancy counter and valid/accept handshake.
module fifo_ram
   import fifo_ram_pkg::*;
#(
   parameter int unsigned Width     = DefaultWidth,
   parameter int unsigned Buffering = DefaultBuffering
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [Width-1:0] InData,
   input  logic             InValid,
   output logic             InAccept,
   output logic [Width-1:0] OutData,
   output logic             OutSend,
   input  logic             OutReady
);

   localparam int unsigned PtrW = ptr_width(Buffering);
   localparam int unsigned CntW = cnt_width(Buffering);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Buffering - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(Buffering);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            accept_q, accept_d;
   logic            send_q, send_d;
   logic            push, pop;

   // Handshake flags are registered copies of the next count, so they depend on state only.
   always_comb begin
      push     = InValid && accept_q;
      pop      = send_q && OutReady;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end

      accept_d = (count_d != FullCnt);
      send_d   = (count_d != '0);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         accept_q <= 1'b1;
         send_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         accept_q <= accept_d;
         send_q   <= send_d;
      end
   end

   assign InAccept = accept_q;
   assign OutSend  = send_q;

   fifo_ram_mem #(
      .Width (Width),
      .Depth (Buffering),
      .AddrW (PtrW)
   ) u_mem (
      .clk_i   (Clock),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (InData),
      .raddr_i (rd_ptr_q),
      .rdata_o (OutData)
   );

endmodule

// File: tb/tb_fifo_ram.sv
// Bench for fifo_ram: queue-based reference model with a negedge monitor, two depths (4 and 3).
module tb_fifo_ram;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] d4, q4, d3, q3;
   logic         v4, a4, s4, r4;
   logic         v3, a3, s3, r3;

   always #5 clk = ~clk;

   fifo_ram #(.Width(W), .Buffering(4)) u_dut4 (
      .Clock(clk), .Reset(rst), .InData(d4), .InValid(v4), .InAccept(a4),
      .OutData(q4), .OutSend(s4), .OutReady(r4)
   );

   fifo_ram #(.Width(W), .Buffering(3)) u_dut3 (
      .Clock(clk), .Reset(rst), .InData(d3), .InValid(v3), .InAccept(a3),
      .OutData(q3), .OutSend(s3), .OutReady(r3)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queues updated on each handshake; capacity decides acceptance.
   logic [W-1:0] m4[$];
   logic [W-1:0] m3[$];
   int sz4, sz3;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m4.delete();
         m3.delete();
      end else begin
         sz4 = m4.size();
         sz3 = m3.size();
         if (r4 && sz4 != 0) void'(m4.pop_front());
         if (v4 && sz4 != 4) m4.push_back(d4);
         if (r3 && sz3 != 0) void'(m3.pop_front());
         if (v3 && sz3 != 3) m3.push_back(d3);
      end
   end

   // Monitor: compare flags every cycle and the head word whenever the model holds data.
   always @(negedge clk) begin
      if (!rst) begin
         check("send4", 32'(s4), 32'(m4.size() != 0));
         check("accept4", 32'(a4), 32'(m4.size() != 4));
         if (m4.size() != 0) check("head4", 32'(q4), 32'(m4[0]));
         check("send3", 32'(s3), 32'(m3.size() != 0));
         check("accept3", 32'(a3), 32'(m3.size() != 3));
         if (m3.size() != 0) check("head3", 32'(q3), 32'(m3[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int idx, cyc, pops, pushed, popped;
      logic acc, pp;

      rst = 1'b1;
      v4 = 0; r4 = 0; d4 = '0;
      v3 = 0; r3 = 0; d3 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_send", 32'(s4), 0);
      check("reset_accept", 32'(a4), 1);

      // single word: one-cycle latency into an empty FIFO
      d4 = 8'hA5; v4 = 1; tick(); v4 = 0;
      check("single_send", 32'(s4), 1);
      check("single_data", 32'(q4), 32'h0A5);
      r4 = 1; tick(); r4 = 0;
      check("single_empty", 32'(s4), 0);

      // fill to capacity with consumer stalled
      for (int i = 1; i <= 4; i++) begin
         d4 = W'(i); v4 = 1; tick();
      end
      check("full_accept", 32'(a4), 0);
      d4 = 8'h05; tick();
      check("held_not_taken", 32'(a4), 0);
      check("held_head", 32'(q4), 32'h01);

      // full + pop: no push that cycle, push lands on the following one
      r4 = 1; tick(); r4 = 0;
      check("after_pop_accept", 32'(a4), 1);
      check("after_pop_head", 32'(q4), 32'h02);
      tick(); v4 = 0;
      check("refull_accept", 32'(a4), 0);
      r4 = 1;
      for (int i = 2; i <= 5; i++) begin
         check("drain_order", 32'(q4), 32'(i));
         tick();
      end
      r4 = 0;
      check("drain_empty", 32'(s4), 0);

      // streaming: one word per cycle with both sides held active
      idx = 0; cyc = 0; pops = 0;
      v4 = 1; r4 = 1;
      while (idx < 20 && cyc < 100) begin
         d4 = W'(8'h10 + idx);
         acc = a4;
         pp = s4;
         tick();
         cyc++;
         if (acc) idx++;
         if (pp) pops++;
      end
      v4 = 0;
      check("stream_cycles", 32'(cyc), 20);
      check("stream_pops", 32'(pops), 19);
      check("stream_tail", 32'(q4), 32'h23);
      tick(); r4 = 0;
      check("stream_empty", 32'(s4), 0);

      // asynchronous reset with two words buffered
      d4 = 8'h31; v4 = 1; tick();
      d4 = 8'h32; tick(); v4 = 0;
      check("pre_reset_send", 32'(s4), 1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_send", 32'(s4), 0);
      check("async_reset_accept", 32'(a4), 1);
      tick();
      rst = 1'b0;
      check("post_reset_accept", 32'(a4), 1);
      check("post_reset_send", 32'(s4), 0);
      d4 = 8'h7E; v4 = 1; tick(); v4 = 0;
      check("post_reset_head", 32'(q4), 32'h7E);
      r4 = 1; tick(); r4 = 0;
      check("post_reset_empty", 32'(s4), 0);

      // depth-3 FIFO: random valid/ready, stalled consumer biased to reach full
      pushed = 0; popped = 0; cyc = 0;
      while (popped < 10 && cyc < 500) begin
         if (!v3 && pushed < 10 && ($urandom_range(0, 1) == 1)) begin
            v3 = 1;
            d3 = W'($urandom);
         end
         r3 = ($urandom_range(0, 3) == 0);
         acc = v3 && a3;
         pp = s3 && r3;
         tick();
         cyc++;
         if (acc) begin
            pushed++;
            v3 = 0;
         end
         if (pp) popped++;
      end
      r3 = 0; v3 = 0;
      check("rand3_pushed", 32'(pushed), 10);
      check("rand3_popped", 32'(popped), 10);
      tick();
      check("rand3_empty", 32'(s3), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
